// File: rtl/ordering_pkg.sv
// Shared widths and types for the ordering path: transaction IDs and payloads.
package ordering_pkg;

  localparam int ID_W   = 3;
  localparam int PLD_W  = 16;
  localparam int NUM_ID = 2 ** ID_W;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [PLD_W-1:0] payload_t;

endpackage

// File: rtl/ordering_rr_arb.sv
// NREQ-wide round-robin arbiter. The search starts at rr_ptr, and the pointer
// moves one past the winner whenever a grant is taken.
module ordering_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_winner;
  logic             w_found;

  // NOTE: every variable in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[(int'(r_rr_ptr) + i) % NREQ]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'((int'(r_rr_ptr) + i) % NREQ);
      end
    end
  end

  assign gnt = (advance && w_found) ? (NREQ'(1) << w_winner) : '0;

  // NOTE: clocked state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (advance && w_found) begin
      r_rr_ptr <= (w_winner == PTR_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
    end
  end

endmodule

// File: rtl/ordering_issue_arb.sv
// Issue scheduler: arbitrates requesters onto the ordering RX port, allocates IDs
// from the pool and frees them on retire. Uses one registered output stage.
module ordering_issue_arb #(
  parameter int NREQ  = 4,
  parameter int ID_W  = ordering_pkg::ID_W,
  parameter int PLD_W = ordering_pkg::PLD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*PLD_W-1:0]   req_payload_i,
  input  logic [NREQ-1:0]         req_order_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [ID_W-1:0]         req_id_o,
  output logic                    ord_valid_o,
  output logic [ID_W-1:0]         ord_id_o,
  output logic [PLD_W-1:0]        ord_payload_o,
  output logic                    ord_order_o,
  input  logic                    ord_ready_i,
  input  logic                    ret_i,
  input  logic [ID_W-1:0]         ret_id_i,
  output logic [(2**ID_W)-1:0]    busy_o,
  output logic [ID_W:0]           outstanding_o,
  output logic                    err_o
);

  localparam int NUM_ID = 2 ** ID_W;

  logic              r_ord_valid;
  logic [ID_W-1:0]   r_ord_id;
  logic [PLD_W-1:0]  r_ord_payload;
  logic              r_ord_order;
  logic [NUM_ID-1:0] r_busy;
  logic [ID_W:0]     r_outstanding;
  logic              r_err;

  logic              w_slot_free;
  logic              w_accept;
  logic [NREQ-1:0]   w_gnt;
  logic [ID_W-1:0]   w_free_id;
  logic [PLD_W-1:0]  w_win_payload;
  logic              w_win_order;
  logic              w_ret_hit;
  logic [NUM_ID-1:0] w_alloc_oh;
  logic [NUM_ID-1:0] w_clr_oh;
  logic [NUM_ID-1:0] w_busy_nxt;
  logic [ID_W:0]     w_cnt_nxt;

  // Allocation reads the registered bitmap, so an ID retired this cycle is not reusable until the next one.
  assign w_slot_free = !r_ord_valid || ord_ready_i;
  assign w_accept    = reset && w_slot_free && (|req_valid_i) && !(&r_busy);

  ordering_rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid_i),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  // Scanning downward lets the lowest clear bit be the last one written.
  always_comb begin
    w_free_id = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_id = ID_W'(i);
    end
  end

  always_comb begin
    w_win_payload = '0;
    w_win_order   = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (w_gnt[r]) begin
        w_win_payload = w_win_payload | req_payload_i[r*PLD_W +: PLD_W];
        w_win_order   = w_win_order | req_order_i[r];
      end
    end
  end

  assign w_ret_hit  = ret_i && r_busy[ret_id_i];
  assign w_alloc_oh = w_accept  ? (NUM_ID'(1) << w_free_id) : '0;
  assign w_clr_oh   = w_ret_hit ? (NUM_ID'(1) << ret_id_i)  : '0;
  assign w_busy_nxt = (r_busy | w_alloc_oh) & ~w_clr_oh;

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      w_cnt_nxt = w_cnt_nxt + (ID_W+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ord_valid   <= 1'b0;
      r_ord_id      <= '0;
      r_ord_payload <= '0;
      r_ord_order   <= 1'b0;
      r_busy        <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ord_valid   <= 1'b1;
        r_ord_id      <= w_free_id;
        r_ord_payload <= w_win_payload;
        r_ord_order   <= w_win_order;
      end else if (ord_ready_i) begin
        r_ord_valid   <= 1'b0;
      end
      r_busy        <= w_busy_nxt;
      r_outstanding <= w_cnt_nxt;
      r_err         <= ret_i && !r_busy[ret_id_i];
    end
  end

  assign req_ready_o   = w_gnt;
  assign req_id_o      = w_free_id;
  assign ord_valid_o   = r_ord_valid;
  assign ord_id_o      = r_ord_id;
  assign ord_payload_o = r_ord_payload;
  assign ord_order_o   = r_ord_order;
  assign busy_o        = r_busy;
  assign outstanding_o = r_outstanding;
  assign err_o         = r_err;

endmodule

// File: tb/tb_ordering_issue_arb.sv
// Self-checking bench for ordering_issue_arb: scoreboard of accepted requests
// plus a cycle model of the pool, pointer and output slot, with directed scenarios.
module tb_ordering_issue_arb;
  import ordering_pkg::*;

  localparam int NREQ = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid, req_order, req_ready;
  logic [NREQ*PLD_W-1:0] req_payload;
  id_t                   req_id, ord_id, ret_id;
  payload_t              ord_payload;
  logic                  ord_valid, ord_order, ord_ready, ret, err;
  logic [NUM_ID-1:0]     busy;
  logic [ID_W:0]         outstanding;

  always #5 clk = ~clk;

  ordering_issue_arb #(.NREQ(NREQ), .ID_W(ID_W), .PLD_W(PLD_W)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .req_valid_i   (req_valid),
    .req_payload_i (req_payload),
    .req_order_i   (req_order),
    .req_ready_o   (req_ready),
    .req_id_o      (req_id),
    .ord_valid_o   (ord_valid),
    .ord_id_o      (ord_id),
    .ord_payload_o (ord_payload),
    .ord_order_o   (ord_order),
    .ord_ready_i   (ord_ready),
    .ret_i         (ret),
    .ret_id_i      (ret_id),
    .busy_o        (busy),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    id_t      id;
    payload_t pld;
    logic     order;
  } exp_t;

  exp_t              sb[$];
  logic              m_valid, m_err, m_acc;
  logic [NUM_ID-1:0] m_busy;
  int                m_rr, m_win, m_free;
  logic [NREQ-1:0]   m_rdy;
  exp_t              m_e;

  // Reference model evaluated between edges; its state reflects the next edge once updated.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_err = 1'b0; m_busy = '0; m_rr = 0;
      sb.delete();
      check("rst_ord_valid", ord_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
    end else begin
      check("ord_valid", ord_valid, m_valid);
      check("busy", busy, m_busy);
      check("outstanding", outstanding, $countones(m_busy));
      check("err", err, m_err);
      if (m_valid && ord_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          m_e = sb.pop_front();
          check("ord_id", ord_id, m_e.id);
          check("ord_payload", ord_payload, m_e.pld);
          check("ord_order", ord_order, m_e.order);
        end
      end
      m_acc = (m_busy != '1) && (!m_valid || ord_ready) && (|req_valid);
      m_rdy = '0;
      m_win = -1;
      m_free = -1;
      if (m_acc) begin
        for (int i = 0; i < NREQ; i++)
          if (m_win < 0 && req_valid[(m_rr + i) % NREQ]) m_win = (m_rr + i) % NREQ;
        for (int i = 0; i < NUM_ID; i++)
          if (m_free < 0 && !m_busy[i]) m_free = i;
        m_rdy[m_win] = 1'b1;
      end
      check("req_ready", req_ready, m_rdy);
      if (m_acc) begin
        check("req_id", req_id, m_free);
        m_e.id    = id_t'(m_free);
        m_e.pld   = req_payload[m_win*PLD_W +: PLD_W];
        m_e.order = req_order[m_win];
        sb.push_back(m_e);
      end
      m_err = ret && !m_busy[ret_id];
      if (ret && m_busy[ret_id]) m_busy[ret_id] = 1'b0;
      if (m_acc) begin
        m_busy[m_free] = 1'b1;
        m_valid = 1'b1;
        m_rr = (m_win + 1) % NREQ;
      end else if (ord_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  id_t      cap_id;
  payload_t cap_pld;
  logic     cap_order;

  initial begin
    req_valid = '0; req_order = '0; req_payload = '0;
    ord_ready = 1'b1; ret = 1'b0; ret_id = '0;
    repeat (2) tick();
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // Single request from requester 0
    req_payload = {16'h4444, 16'h3333, 16'h2222, 16'hA5A5};
    req_valid = 4'b0001; req_order = 4'b0001;
    #1;
    check("single_ready", req_ready, 4'b0001);
    check("single_id", req_id, 0);
    tick();
    check("single_ord_valid", ord_valid, 1);
    check("single_ord_id", ord_id, 0);
    check("single_ord_payload", ord_payload, 16'hA5A5);
    check("single_ord_order", ord_order, 1);
    check("single_busy", busy, 8'h01);
    req_valid = '0;
    tick();

    // Retire of an ID that is not allocated
    ret = 1'b1; ret_id = 3'd3;
    tick();
    ret = 1'b0;
    check("bad_ret_err", err, 1);
    check("bad_ret_busy", busy, 8'h01);
    tick();
    check("bad_ret_err_drop", err, 0);
    ret = 1'b1; ret_id = 3'd0;
    tick();
    ret = 1'b0;
    check("ret0_busy", busy, 8'h00);

    // Four allocations, then leave the slot stuck and reset mid-flight
    req_valid = 4'b1111; req_order = 4'b0101;
    repeat (4) tick();
    req_valid = '0; ord_ready = 1'b0;
    tick();
    check("pre_rst_busy", busy, 8'h0F);
    check("pre_rst_valid", ord_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ord_valid, 0);
    check("mid_rst_id", ord_id, 0);
    check("mid_rst_payload", ord_payload, 0);
    check("mid_rst_order", ord_order, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_outstanding", outstanding, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1; ord_ready = 1'b1; req_valid = 4'b1111;
    #1;

    // Round-robin across all requesters until the pool is exhausted
    for (int i = 0; i < NUM_ID; i++) begin
      check("rr_ready", req_ready, 4'b0001 << (i % NREQ));
      check("rr_id", req_id, i);
      tick();
    end
    check("full_busy", busy, 8'hFF);
    check("full_outstanding", outstanding, 8);
    check("full_ready", req_ready, 0);

    // Retire into a full pool: ID 5 becomes allocatable one cycle later
    ret = 1'b1; ret_id = 3'd5;
    #1;
    check("ret_cycle_ready", req_ready, 0);
    tick();
    ret = 1'b0;
    check("ret5_busy", busy, 8'hDF);
    #1;
    check("realloc_ready", req_ready, 4'b0001);
    check("realloc_id", req_id, 5);
    tick();
    check("refull_busy", busy, 8'hFF);

    // Drain the pool
    req_valid = '0;
    ret = 1'b1;
    for (int i = 0; i < NUM_ID; i++) begin
      ret_id = id_t'(i);
      tick();
    end
    ret = 1'b0;
    check("drain_busy", busy, 8'h00);
    check("drain_outstanding", outstanding, 0);

    // Backpressure: hold for 3 cycles, then same-cycle refill
    req_payload = {16'hD00D, 16'hC0DE, 16'hBEEF, 16'h1234};
    req_valid = 4'b1111; ord_ready = 1'b0;
    tick();
    check("bp_valid", ord_valid, 1);
    check("bp_first_id", ord_id, 0);
    check("bp_first_payload", ord_payload, 16'hBEEF);
    cap_id = ord_id; cap_pld = ord_payload; cap_order = ord_order;
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", req_ready, 0);
      tick();
      check("bp_hold_valid", ord_valid, 1);
      check("bp_hold_id", ord_id, cap_id);
      check("bp_hold_payload", ord_payload, cap_pld);
      check("bp_hold_order", ord_order, cap_order);
    end
    ord_ready = 1'b1;
    #1;
    check("bp_refill_ready", req_ready, 4'b0100);
    tick();
    check("bp_refill_valid", ord_valid, 1);
    check("bp_refill_id", ord_id, 1);
    check("bp_refill_payload", ord_payload, 16'hC0DE);

    req_valid = '0;
    repeat (3) tick();
    check("sb_leftover", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
